// File: rtl/m_madd_pkg.sv
// Shared encodings and defaults for the multiply-add scheduler and its arbiter.
package m_madd_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e own;
  } tag_t;

  localparam int unsigned LAT_DEF = 3;

endpackage

// File: rtl/m_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant flag moves only when a grant is issued.
module m_rr_arb2
  import m_madd_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   vld_a_i,
  input  logic   vld_b_i,
  input  logic   en_i,
  output logic   gnt_a_o,
  output logic   gnt_b_o,
  output owner_e last_o
);

  owner_e last_q, last_d;

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    gnt_a_o = en_i & vld_a_i & (~vld_b_i | (last_q == OWN_B));
    gnt_b_o = en_i & vld_b_i & (~vld_a_i | (last_q == OWN_A));
    last_d  = last_q;
    if (gnt_a_o)      last_d = OWN_A;
    else if (gnt_b_o) last_d = OWN_B;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= OWN_B;
    else       last_q <= last_d;
  end

  assign last_o = last_d;

endmodule

// File: rtl/m_madd_sched.sv
// Round-robin issue scheduler for the shared multiply-add pipeline with owner-tag result return.
// Optional handshake counters w_cnt_a/w_cnt_b when MADD_SCHED_STATS_EN is defined.
module m_madd_sched
  import m_madd_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEF
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_vld_a,
  input  logic        w_vld_b,
  output logic        w_rdy_a,
  output logic        w_rdy_b,
  input  logic [15:0] w_in1_a,
  input  logic [15:0] w_in1_b,
  input  logic [31:0] w_in2_a,
  input  logic [31:0] w_in2_b,
  output logic [31:0] w_y_a,
  output logic [31:0] w_y_b,
  output logic        w_yv_a,
  output logic        w_yv_b,
  output logic [15:0] w_m_in1,
  output logic [31:0] w_m_in2,
  input  logic [31:0] w_m_y,
  input  logic        w_drain,
  output logic        w_idle
`ifdef MADD_SCHED_STATS_EN
  ,
  output logic [31:0] w_cnt_a,
  output logic [31:0] w_cnt_b
`endif
);

  state_e      state_q, state_d;
  tag_t        tag_q [LAT+1];
  tag_t        tag_d;
  tag_t        tag_exit;
  owner_e      own_nxt;
  logic        gnt_a, gnt_b, hs, busy;
  logic [15:0] m_in1_q, m_in1_d;
  logic [31:0] m_in2_q, m_in2_d;
  logic [31:0] y_a_q, y_b_q;
  logic        yv_a_q, yv_b_q;

  m_rr_arb2 u_arb (
    .clk_i   (w_clk),
    .rst_i   (w_rst),
    .vld_a_i (w_vld_a),
    .vld_b_i (w_vld_b),
    .en_i    ((state_q == ST_RUN) & ~w_drain),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b),
    .last_o  (own_nxt)
  );

  assign w_rdy_a  = gnt_a;
  assign w_rdy_b  = gnt_b;
  assign hs       = gnt_a | gnt_b;
  assign tag_exit = tag_q[LAT];

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i <= LAT; i++) busy = busy | tag_q[i].vld;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (w_drain) state_d = ST_DRAIN;
      ST_DRAIN: if (!w_drain) state_d = ST_RUN;
                else if (!busy) state_d = ST_IDLE;
      ST_IDLE:  if (!w_drain) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Idle cycles still push a bubble tag and zero operands so the pipeline sees clean input.
  always_comb begin
    tag_d.vld = hs;
    tag_d.own = own_nxt;
    m_in1_d   = 16'd0;
    m_in2_d   = 32'd0;
    if (gnt_a) begin
      m_in1_d = w_in1_a;
      m_in2_d = w_in2_a;
    end else if (gnt_b) begin
      m_in1_d = w_in1_b;
      m_in2_d = w_in2_b;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= ST_RUN;
      m_in1_q <= 16'd0;
      m_in2_q <= 32'd0;
      y_a_q   <= 32'd0;
      y_b_q   <= 32'd0;
      yv_a_q  <= 1'b0;
      yv_b_q  <= 1'b0;
      for (int unsigned i = 0; i <= LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      m_in1_q  <= m_in1_d;
      m_in2_q  <= m_in2_d;
      tag_q[0] <= tag_d;
      for (int unsigned i = 1; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
      yv_a_q   <= tag_exit.vld & (tag_exit.own == OWN_A);
      yv_b_q   <= tag_exit.vld & (tag_exit.own == OWN_B);
      if (tag_exit.vld && tag_exit.own == OWN_A) y_a_q <= w_m_y;
      if (tag_exit.vld && tag_exit.own == OWN_B) y_b_q <= w_m_y;
    end
  end

  assign w_m_in1 = m_in1_q;
  assign w_m_in2 = m_in2_q;
  assign w_y_a   = y_a_q;
  assign w_y_b   = y_b_q;
  assign w_yv_a  = yv_a_q;
  assign w_yv_b  = yv_b_q;
  assign w_idle  = (state_q == ST_IDLE);

`ifdef MADD_SCHED_STATS_EN
  logic [31:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      cnt_a_q <= 32'd0;
      cnt_b_q <= 32'd0;
    end else begin
      cnt_a_q <= cnt_a_q + 32'(gnt_a);
      cnt_b_q <= cnt_b_q + 32'(gnt_b);
    end
  end

  assign w_cnt_a = cnt_a_q;
  assign w_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_m_madd_sched.sv
// Bench for m_madd_sched: behavioural pipeline plus an issue/return model built from queues.
module tb_m_madd_sched;
  import m_madd_pkg::*;

  localparam int LAT = int'(LAT_DEF);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld_a = 1'b0, vld_b = 1'b0, drain = 1'b0;
  logic        rdy_a, rdy_b, yv_a, yv_b, idle;
  logic [15:0] in1_a = '0, in1_b = '0, m_in1;
  logic [31:0] in2_a = '0, in2_b = '0, m_in2, m_y, y_a, y_b;
`ifdef MADD_SCHED_STATS_EN
  logic [31:0] cnt_a, cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_madd_sched #(.LAT(LAT_DEF)) dut (
    .w_clk   (clk),
    .w_rst   (rst),
    .w_vld_a (vld_a),
    .w_vld_b (vld_b),
    .w_rdy_a (rdy_a),
    .w_rdy_b (rdy_b),
    .w_in1_a (in1_a),
    .w_in1_b (in1_b),
    .w_in2_a (in2_a),
    .w_in2_b (in2_b),
    .w_y_a   (y_a),
    .w_y_b   (y_b),
    .w_yv_a  (yv_a),
    .w_yv_b  (yv_b),
    .w_m_in1 (m_in1),
    .w_m_in2 (m_in2),
    .w_m_y   (m_y),
    .w_drain (drain),
    .w_idle  (idle)
`ifdef MADD_SCHED_STATS_EN
    ,
    .w_cnt_a (cnt_a),
    .w_cnt_b (cnt_b)
`endif
  );

  function automatic logic [31:0] madd(input logic [15:0] a, input logic [31:0] b);
    return 32'(a) * b + 32'h0001_0001;
  endfunction

  // Stand-in for the shared pipeline: result valid LAT edges after operands appear.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= madd(m_in1, m_in2);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign m_y = pipe[LAT-1];

  typedef struct {
    int          due;
    bit          own_b;
    logic [31:0] val;
  } op_t;

  op_t         inflight[$];
  int          cyc = 0;
  int          mode = 0;      // 0 running, 1 draining, 2 idle
  bit          last_b = 1'b1;
  logic [31:0] ey_a = '0, ey_b = '0;
  int          na = 0, nb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    mode   = 0;
    last_b = 1'b1;
    ey_a   = '0;
    ey_b   = '0;
    na     = 0;
    nb     = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    vld_a = 1'b0;
    vld_b = 1'b0;
    drain = 1'b0;
    rst   = 1'b1;
    #1;
    chk("rst_y_a", y_a, 32'd0);
    chk("rst_y_b", y_b, 32'd0);
    chk("rst_yv_a", {31'd0, yv_a}, 32'd0);
    chk("rst_yv_b", {31'd0, yv_b}, 32'd0);
    chk("rst_m_in1", {16'd0, m_in1}, 32'd0);
    chk("rst_m_in2", m_in2, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd0);
`ifdef MADD_SCHED_STATS_EN
    chk("rst_cnt_a", cnt_a, 32'd0);
    chk("rst_cnt_b", cnt_b, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit va, input bit vb,
                      input logic [15:0] a1, input logic [31:0] a2,
                      input logic [15:0] b1, input logic [31:0] b2,
                      input bit dr);
    bit   ga, gb, running, empty, eva, evb;
    op_t  op;
    logic [15:0] e1;
    logic [31:0] e2;
    @(negedge clk);
    vld_a = va; vld_b = vb; in1_a = a1; in2_a = a2; in1_b = b1; in2_b = b2; drain = dr;
    #1;
    running = (mode == 0) && !dr;
    ga = running && va && (!vb || last_b);
    gb = running && vb && (!va || !last_b);
    chk("rdy_a", {31'd0, rdy_a}, {31'd0, ga});
    chk("rdy_b", {31'd0, rdy_b}, {31'd0, gb});
    @(posedge clk);
    cyc++;
    empty = (inflight.size() == 0);
    case (mode)
      0: if (dr) mode = 1;
      1: if (!dr) mode = 0; else if (empty) mode = 2;
      default: if (!dr) mode = 0;
    endcase
    e1 = '0; e2 = '0;
    if (ga || gb) begin
      op.due   = cyc + LAT + 1;
      op.own_b = gb;
      e1       = ga ? a1 : b1;
      e2       = ga ? a2 : b2;
      op.val   = madd(e1, e2);
      inflight.push_back(op);
      last_b = gb;
      if (ga) na++; else nb++;
    end
    eva = 1'b0; evb = 1'b0;
    if (inflight.size() > 0 && inflight[0].due == cyc) begin
      op = inflight.pop_front();
      if (op.own_b) begin evb = 1'b1; ey_b = op.val; end
      else          begin eva = 1'b1; ey_a = op.val; end
    end
    #1;
    chk("m_in1", {16'd0, m_in1}, {16'd0, e1});
    chk("m_in2", m_in2, e2);
    chk("yv_a", {31'd0, yv_a}, {31'd0, eva});
    chk("yv_b", {31'd0, yv_b}, {31'd0, evb});
    chk("y_a", y_a, ey_a);
    chk("y_b", y_b, ey_b);
    chk("idle", {31'd0, idle}, {31'd0, (mode == 2)});
`ifdef MADD_SCHED_STATS_EN
    chk("cnt_a", cnt_a, 32'(na));
    chk("cnt_b", cnt_b, 32'(nb));
`endif
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, '0, 0);
  endtask

  initial begin
    bit dr_r;
    // Reset, then A alone with 3 x 4.
    do_reset();
    nop(9);
    step(1, 0, 16'd3, 32'd4, '0, '0, 0);
    nop(LAT + 2);
    chk("a_alone_result", y_a, 32'h0001_000D);
    chk("a_alone_no_b", y_b, 32'd0);

    // Tie for six cycles from reset: A first, then alternating.
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1, 1, 16'(i + 1), 32'(100 + i), 16'(i + 11), 32'(200 + i), 0);
    nop(LAT + 2);
    chk("tie_last_b", y_b, madd(16'd16, 32'd205));
    chk("tie_last_a", y_a, madd(16'd5, 32'd104));

    // A streaming every cycle, B idle.
    for (int i = 0; i < 8; i++)
      step(1, 0, 16'($urandom), $urandom, '0, '0, 0);
    nop(LAT + 3);

    // Drain with three operations in flight, requesters still valid.
    step(1, 0, 16'd7, 32'd9, '0, '0, 0);
    step(0, 1, '0, '0, 16'd8, 32'd10, 0);
    step(1, 0, 16'd11, 32'd12, '0, '0, 0);
    for (int i = 0; i < LAT + 4; i++)
      step(1, 1, 16'd1, 32'd1, 16'd2, 32'd2, 1);
    chk("drain_idle", {31'd0, idle}, 32'd1);
    step(1, 1, 16'd5, 32'd6, 16'd7, 32'd8, 0);
    nop(LAT + 2);

    // Reset two cycles after an issue: that result never returns.
    step(0, 1, '0, '0, 16'd21, 32'd22, 0);
    nop(2);
    do_reset();
    nop(LAT + 3);
    chk("rst_mid_y_b", y_b, 32'd0);

    // Stats: five A and three B handshakes.
    for (int i = 0; i < 5; i++) step(1, 0, 16'(i), 32'(i), '0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, '0, '0, 16'(i), 32'(i), 0);
    nop(LAT + 2);
`ifdef MADD_SCHED_STATS_EN
    chk("cnt_a_5", cnt_a, 32'd5);
    chk("cnt_b_3", cnt_b, 32'd3);
`endif
    do_reset();

    // Random traffic with occasional drain periods.
    dr_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) dr_r = ~dr_r;
      step(1'($urandom), 1'($urandom), 16'($urandom), $urandom,
           16'($urandom), $urandom, dr_r);
    end
    nop(LAT + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
